// File: rtl/matrix_reader.sv
// matrix_reader
//   Streams one stored matrix out element by element over a valid/ready
//   interface, in row-major order or column-major (transposed) order.
//   The reader drives a (slot,row,col) read address and the surrounding
//   logic returns the addressed element combinationally on rd_data.
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start/start_slot  1-cycle read request for a slot, with transpose mode
//   abort             cancel the read in progress
//   slot_valid        per-slot valid flags; dim_m/dim_n describe rd_slot
//   rd_slot/row/col   read address; rd_data element at that address
//   out_*             registered stream element with source indices and
//                     end-of-line / last markers; out_ready accepts it
//   busy/done/err     status; done and err are 1-cycle pulses
module matrix_reader #(
  parameter int MAX_DIM    = 5,
  parameter int MAX_STORE  = 2,
  parameter int ELEM_WIDTH = 8,
  localparam int SLOT_BITS = (MAX_STORE > 1) ? $clog2(MAX_STORE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SLOT_BITS-1:0]  start_slot,
  input  logic                  transpose,
  input  logic                  abort,
  input  logic [MAX_STORE-1:0]  slot_valid,
  input  logic [3:0]            dim_m,
  input  logic [3:0]            dim_n,
  output logic [SLOT_BITS-1:0]  rd_slot,
  output logic [3:0]            rd_row,
  output logic [3:0]            rd_col,
  input  logic [ELEM_WIDTH-1:0] rd_data,
  output logic [ELEM_WIDTH-1:0] out_elem,
  output logic [3:0]            out_row,
  output logic [3:0]            out_col,
  output logic                  out_eol,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  localparam logic [3:0] MAX_DIM_4 = 4'(MAX_DIM);

  logic [1:0]            state_q, state_d;
  logic [SLOT_BITS-1:0]  rd_slot_q, rd_slot_d;
  logic [3:0]            rd_row_q, rd_row_d;
  logic [3:0]            rd_col_q, rd_col_d;
  logic                  transpose_q, transpose_d;
  logic [3:0]            m_q, m_d;
  logic [3:0]            n_q, n_d;
  logic [4:0]            issued_q, issued_d;
  logic [ELEM_WIDTH-1:0] out_elem_q, out_elem_d;
  logic [3:0]            out_row_q, out_row_d;
  logic [3:0]            out_col_q, out_col_d;
  logic                  out_eol_q, out_eol_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [7:0]            total;
  logic                  load;
  logic                  bad_dims;

  always_comb begin
    state_d     = state_q;
    rd_slot_d   = rd_slot_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    transpose_d = transpose_q;
    m_d         = m_q;
    n_d         = n_q;
    issued_d    = issued_q;
    out_elem_d  = out_elem_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_eol_d   = out_eol_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load        = 1'b0;
    total       = {4'b0, m_q} * {4'b0, n_q};
    bad_dims    = (dim_m == 4'd0) || (dim_m > MAX_DIM_4) ||
                  (dim_n == 4'd0) || (dim_n > MAX_DIM_4);

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_slot_d   = start_slot;
          transpose_d = transpose;
          busy_d      = 1'b1;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!slot_valid[rd_slot_q] || bad_dims) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          m_d      = dim_m;
          n_d      = dim_n;
          rd_row_d = '0;
          rd_col_d = '0;
          issued_d = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (abort) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          load = (!out_valid_q || out_ready) && ({3'b0, issued_q} < total);
          if (load) begin
            out_elem_d  = rd_data;
            out_row_d   = rd_row_q;
            out_col_d   = rd_col_q;
            out_eol_d   = transpose_q ? (rd_row_q == m_q - 4'd1)
                                      : (rd_col_q == n_q - 4'd1);
            out_last_d  = ({3'b0, issued_q} == total - 8'd1);
            out_valid_d = 1'b1;
            issued_d    = issued_q + 5'd1;
            // Address walks past the final element harmlessly; it is
            // re-zeroed in CHECK before the next stream.
            if (transpose_q) begin
              if (rd_row_q == m_q - 4'd1) begin
                rd_row_d = '0;
                rd_col_d = rd_col_q + 4'd1;
              end else begin
                rd_row_d = rd_row_q + 4'd1;
              end
            end else begin
              if (rd_col_q == n_q - 4'd1) begin
                rd_col_d = '0;
                rd_row_d = rd_row_q + 4'd1;
              end else begin
                rd_col_d = rd_col_q + 4'd1;
              end
            end
          end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_slot_q   <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      transpose_q <= 1'b0;
      m_q         <= '0;
      n_q         <= '0;
      issued_q    <= '0;
      out_elem_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_slot_q   <= rd_slot_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      transpose_q <= transpose_d;
      m_q         <= m_d;
      n_q         <= n_d;
      issued_q    <= issued_d;
      out_elem_q  <= out_elem_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_eol_q   <= out_eol_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rd_slot   = rd_slot_q;
  assign rd_row    = rd_row_q;
  assign rd_col    = rd_col_q;
  assign out_elem  = out_elem_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_eol   = out_eol_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_matrix_reader.sv
// tb_matrix_reader
//   Scoreboard bench: each read request pushes the expected element
//   sequence into a queue; a monitor compares every presented element
//   against the queue head and pops on acceptance.
module tb_matrix_reader;

  typedef struct packed {
    logic [7:0] v;
    logic [3:0] r;
    logic [3:0] c;
    logic       eol;
    logic       last;
  } elem_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [0:0] start_slot = '0;
  logic       transpose = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] slot_valid = '0;
  logic [3:0] dim_m, dim_n;
  logic [0:0] rd_slot;
  logic [3:0] rd_row, rd_col;
  logic [7:0] rd_data;
  logic [7:0] out_elem;
  logic [3:0] out_row, out_col;
  logic       out_eol, out_last, out_valid;
  logic       out_ready = 1'b1;
  logic       busy, done, err;

  logic [7:0] mem [0:1][0:15][0:15];
  logic [3:0] dm [0:1];
  logic [3:0] dn [0:1];

  assign rd_data = mem[rd_slot][rd_row][rd_col];
  assign dim_m   = dm[rd_slot];
  assign dim_n   = dn[rd_slot];

  matrix_reader #(.MAX_DIM(5), .MAX_STORE(2), .ELEM_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_slot(start_slot),
    .transpose(transpose), .abort(abort), .slot_valid(slot_valid),
    .dim_m(dim_m), .dim_n(dim_n), .rd_slot(rd_slot), .rd_row(rd_row),
    .rd_col(rd_col), .rd_data(rd_data), .out_elem(out_elem),
    .out_row(out_row), .out_col(out_col), .out_eol(out_eol),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  elem_t q[$];
  int    checks = 0;
  int    fails = 0;
  int    done_cnt = 0;
  int    err_cnt = 0;
  int    acc_cnt = 0;
  int    ready_mode = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Ready pattern generator: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          out_ready = (ph % 4 == 0) || (ph % 4 == 3);
          ph++;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: every presented element must equal the queue head.
  initial begin
    elem_t got;
    forever begin
      @(negedge clk);
      if (rst_n && !abort) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (out_valid) begin
          got = '{v: out_elem, r: out_row, c: out_col, eol: out_eol, last: out_last};
          checks++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_elem: got v=%0d r=%0d c=%0d with empty queue", out_elem, out_row, out_col);
          end else begin
            if (got != q[0]) begin
              fails++;
              $display("FAIL stream_elem: got v=%0d r=%0d c=%0d eol=%0d last=%0d expected v=%0d r=%0d c=%0d eol=%0d last=%0d",
                       got.v, got.r, got.c, got.eol, got.last,
                       q[0].v, q[0].r, q[0].c, q[0].eol, q[0].last);
            end
            if (out_ready) begin
              void'(q.pop_front());
              acc_cnt++;
            end
          end
        end
      end
    end
  end

  // Reference: enumerate the matrix in the requested order.
  task automatic push_expected(input int slot, input bit tr);
    int m, n, r, c;
    m = int'(dm[slot]);
    n = int'(dn[slot]);
    for (int i = 0; i < m * n; i++) begin
      if (tr) begin r = i % m; c = i / m; end
      else    begin r = i / n; c = i % n; end
      q.push_back('{v: mem[slot][r][c], r: 4'(r), c: 4'(c),
                    eol: tr ? (r == m - 1) : (c == n - 1),
                    last: (i == m * n - 1)});
    end
  endtask

  task automatic pulse_start(input int slot, input bit tr);
    @(posedge clk); #1;
    start = 1'b1; start_slot = 1'(slot); transpose = tr;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_read(input int slot, input bit tr, input int mode);
    bit good;
    int m, n, cyc, d0, e0, a0;
    m = int'(dm[slot]);
    n = int'(dn[slot]);
    good = slot_valid[slot] && m >= 1 && m <= 5 && n >= 1 && n <= 5;
    ready_mode = mode;
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    if (good) push_expected(slot, tr);
    pulse_start(slot, tr);
    check("busy_after_start", int'(busy), 1);
    if (!good) begin
      @(posedge clk); #1;
      check("err_pulse", int'(err), 1);
      check("err_no_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      check("err_busy_low", int'(busy), 0);
      check("err_one_cycle", int'(err), 0);
      repeat (2) @(posedge clk);
      #1;
      check("err_count", err_cnt - e0, 1);
      check("err_no_done", done_cnt - d0, 0);
      return;
    end
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("first_valid_latency", cyc, 2);
    cyc = 0;
    while (busy && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_finished", int'(busy), 0);
    check("done_with_busy_drop", int'(done), 1);
    if (mode == 0) check("stream_cycles", cyc, m * n);
    repeat (2) @(posedge clk);
    #1;
    check("done_count", done_cnt - d0, 1);
    check("accepted_count", acc_cnt - a0, m * n);
    check("queue_drained", q.size(), 0);
    check("no_err", err_cnt - e0, 0);
  endtask

  task automatic run_cancel(input bit use_reset);
    int d0, a0, cyc;
    slot_valid[0] = 1'b1; dm[0] = 4'd5; dn[0] = 4'd5;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) mem[0][r][c] = 8'($urandom);
    ready_mode = 0;
    d0 = done_cnt; a0 = acc_cnt;
    push_expected(0, 1'b0);
    pulse_start(0, 1'b0);
    cyc = 0;
    while (acc_cnt - a0 < 3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("cancel_reached_3", acc_cnt - a0, 3);
    if (use_reset) rst_n = 1'b0; else abort = 1'b1;
    @(posedge clk); #1;
    check(use_reset ? "reset_valid_low" : "abort_valid_low", int'(out_valid), 0);
    check(use_reset ? "reset_busy_low" : "abort_busy_low", int'(busy), 0);
    check(use_reset ? "reset_no_done" : "abort_no_done", int'(done), 0);
    if (use_reset) begin
      check("reset_rd_addr", int'({rd_slot, rd_row, rd_col}), 0);
      check("reset_out_fields", int'({out_elem, out_row, out_col, out_eol, out_last}), 0);
    end
    rst_n = 1'b1; abort = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("cancel_no_done_later", done_cnt - d0, 0);
    check("cancel_still_idle", int'(out_valid), 0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) mem[s][r][c] = '0;
    dm[0] = 4'd2; dn[0] = 4'd3; dm[1] = 4'd0; dn[1] = 4'd0;
    for (int i = 0; i < 6; i++) mem[0][i / 3][i % 3] = 8'(i + 1);
    slot_valid = 2'b01;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({out_valid, busy, done, err, out_eol, out_last}), 0);
    check("reset_addr", int'({rd_slot, rd_row, rd_col}), 0);
    rst_n = 1'b1;

    run_read(0, 1'b0, 0);
    run_read(0, 1'b1, 0);
    run_read(0, 1'b0, 1);
    run_read(0, 1'b1, 1);

    run_read(1, 1'b0, 0);
    slot_valid[1] = 1'b1; dm[1] = 4'd0; dn[1] = 4'd3;
    run_read(1, 1'b0, 0);
    dm[1] = 4'd6;
    run_read(1, 1'b1, 0);

    run_cancel(1'b0);
    run_read(0, 1'b0, 0);
    run_cancel(1'b1);
    run_read(0, 1'b1, 2);

    dm[0] = 4'd1; dn[0] = 4'd1; mem[0][0][0] = 8'hA5;
    run_read(0, 1'b0, 0);

    for (int it = 0; it < 25; it++) begin
      int s;
      s = int'($urandom_range(0, 1));
      slot_valid[s] = ($urandom_range(0, 7) != 0);
      dm[s] = 4'($urandom_range(1, 5));
      dn[s] = 4'($urandom_range(1, 5));
      if ($urandom_range(0, 7) == 0) dn[s] = 4'($urandom_range(6, 15));
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) mem[s][r][c] = 8'($urandom);
      run_read(s, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
